// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, redirect kinds,
// default reset PC and the immediate sign-extension helper.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic KIND_JAL  = 1'b0;
  localparam logic KIND_JALR = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  function automatic logic [31:0] sext_imm(input logic [20:0] imm);
    return {{11{imm[20]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect target: base + sext(imm), bit 0 cleared for JALR,
// and a flag when the resulting target is not 4-byte aligned in bit 1.
module fetch_target_calc
  import riscv_fetch_pkg::*;
(
  input  logic        kind,
  input  logic [20:0] imm,
  input  logic [31:0] base,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] sum;

  always_comb begin
    sum    = base + sext_imm(imm);
    target = sum;
    if (kind == KIND_JALR) begin
      target[0] = 1'b0;
    end
    misalign = target[1];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, FETCH/WAIT/HOLD
// sequencing, redirect handling with a single kill bit for in-flight responses.
module fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic        redirect_kind,
  input  logic [20:0] redirect_imm,
  input  logic [31:0] redirect_base,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  req_pc, req_pc_n;
  logic         kill, kill_n;
  logic [31:0]  inst_n, inst_pc_n;
  logic         inst_valid_n, misalign_n;

  logic [31:0]  target;
  logic         target_misalign;
  logic         redirect_ok;
  logic         req_fire;

  fetch_target_calc u_target (
    .kind     (redirect_kind),
    .imm      (redirect_imm),
    .base     (redirect_base),
    .target   (target),
    .misalign (target_misalign)
  );

  // Misaligned targets are dropped outright; only the pulse remains visible.
  assign redirect_ok = redirect_valid && !target_misalign;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    req_pc_n       = req_pc;
    kill_n         = kill;
    inst_n         = inst;
    inst_pc_n      = inst_pc;
    inst_valid_n   = inst_valid;
    misalign_n     = redirect_valid && target_misalign;
    imem_req_valid = (state == FETCH) && !stall && !reset;
    imem_addr      = reset ? RESET_PC : pc;
    req_fire       = imem_req_valid && imem_req_ready;

    case (state)
      FETCH: begin
        if (req_fire) begin
          req_pc_n = pc;
          pc_n     = pc + PC_STEP;
          state_n  = WAIT;
        end
        if (redirect_ok) begin
          pc_n = target;
          if (req_fire) begin
            kill_n = 1'b1;
          end
        end
      end
      WAIT: begin
        if (redirect_ok) begin
          pc_n = target;
          if (imem_rsp_valid) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            inst_n       = imem_rsp_data;
            inst_pc_n    = req_pc;
            inst_valid_n = 1'b1;
            state_n      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_ok) begin
          pc_n         = target;
          inst_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (inst_ready) begin
          inst_valid_n = 1'b0;
          state_n      = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_pc     <= req_pc_n;
      kill       <= kill_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
      misalign   <= misalign_n;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  blocks issue of new instruction-memory requests.
REQ-005 redirect_valid  in  1  one-cycle request to change fetch flow.
REQ-006 redirect_kind  in  1  0 = JAL (base+sext(imm)), 1 = JALR ((base+sext(imm)) & ~1).
REQ-007 redirect_imm  in  21  signed byte offset.
REQ-008 redirect_base  in  32  base address (PC for JAL, rs1 for JALR).
REQ-009 imem_req_valid  out  1  request valid; imem_addr  out  32  request address.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_rsp_valid  in  1  response valid; imem_rsp_data  in  32  instruction word.
REQ-012 inst_valid  out  1 / inst  out  32 / inst_pc  out  32  fetched instruction to decode.
REQ-013 inst_ready  in  1  decode accepts inst.
REQ-014 misalign  out  1  one-cycle pulse when a redirect target has bit 1 set.

Function
REQ-015 The FSM SHALL have states FETCH, WAIT and HOLD; only one memory request is outstanding at any time.
REQ-016 FETCH: imem_req_valid = !stall; imem_addr = pc; on valid&&ready, req_pc <= pc, pc <= pc+4 (mod 2^32, 0xFFFF_FFFC -> 0), next state WAIT.
REQ-017 WAIT: on imem_rsp_valid with kill=0, inst <= imem_rsp_data, inst_pc <= req_pc, inst_valid <= 1, next state HOLD; with kill=1, drop the data, clear kill, next state FETCH.
REQ-018 HOLD: inst, inst_pc and inst_valid SHALL stay stable until inst_ready; on the handshake, inst_valid <= 0 and next state FETCH. The FSM SHALL insert no bypass and SHALL accept a one-bubble penalty.
REQ-019 The redirect target SHALL be computed as base + sign-extended 21-bit immediate, modulo 2^32; for JALR, bit 0 SHALL be cleared.
REQ-020 If the target has bit 1 set, the redirect SHALL be ignored and misalign SHALL pulse on the next cycle.
REQ-021 A valid redirect in FETCH SHALL set pc <= target; if a request handshakes in the same cycle, that request SHALL issue with the old pc, kill <= 1, and next state WAIT.
REQ-022 A valid redirect in WAIT SHALL set pc <= target and kill <= 1; if imem_rsp_valid is high in the same cycle, the response SHALL be discarded and next state FETCH, with kill left 0.
REQ-023 A valid redirect in HOLD SHALL set pc <= target, inst_valid <= 0 and next state FETCH, even if inst_ready is high in the same cycle (redirect wins, no consumption).
REQ-024 On back-to-back redirects, the latest target SHALL win; kill SHALL remain a single bit.
REQ-025 Redirect SHALL take priority over stall; stall SHALL affect FETCH only.

Reset
REQ-026 While reset is high: state <= FETCH, pc <= RESET_PC, kill <= 0, inst_valid <= 0, inst <= 0, inst_pc <= 0, misalign <= 0, imem_req_valid = 0, imem_addr = RESET_PC.
REQ-027 Reset mid-operation SHALL abandon any outstanding request; the first response after reset SHALL be ignored only if it arrives before the first new request issues.

Structure
REQ-028 A shared package riscv_fetch_pkg SHALL hold the state enum, redirect-kind constants (KIND_JAL, KIND_JALR) and the RESET_PC default.
REQ-029 A sub-module fetch_target_calc SHALL perform the sign extension, the 32-bit add, the JALR bit-0 clear and the misalign flag, all combinationally.

Verification
REQ-030 Reset with RESET_PC=0x100 and ready/rsp tied high -> requests at 0x100, 0x104, 0x108; inst_pc follows in order.
REQ-031 JAL with base=0x200, imm=0x1FFFF8 (-8) during WAIT -> in-flight response dropped; next request at 0x1F8.
REQ-032 JALR with base=0x301, imm=0x000003 -> target 0x304 (bit 0 cleared); base=0x300, imm=0x2 -> misalign pulse and pc unchanged.
REQ-033 pc=0xFFFF_FFFC handshake -> next request at 0x0000_0000.
REQ-034 HOLD with inst_ready low for 5 cycles -> inst and inst_pc stable; redirect with inst_ready high -> instruction not consumed and fetch resumes at the target.
REQ-035 stall high in FETCH with a redirect -> no request issued while stall is high; pc updates to the target; the request issues at the target once stall falls.
